// File: rtl/fp_pkg.sv
// Shared FP datapath definitions.
// Normalizer state encoding and default widths.
package fp_pkg;
  localparam int MANT_W = 24;
  localparam int EXP_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } norm_state_t;
endpackage

// File: rtl/lzd_window.sv
// Leading-zero count of a small window.
// Result saturates at W when the window is all zero.
module lzd_window #(
  parameter int W = 4
) (
  input  logic [W-1:0]           win,
  output logic [$clog2(W+1)-1:0] lz
);
  localparam int CW = $clog2(W+1);

  always_comb begin
    lz = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (win[i]) lz = CW'(W - 1 - i);
    end
  end
endmodule

// File: rtl/norm_shift_seq.sv
// Iterative left-shift normalizer.
// Shifts up to MAX_STEP bits per cycle, bounded by the exponent.
module norm_shift_seq #(
  parameter int MANT_W   = fp_pkg::MANT_W,
  parameter int EXP_W    = fp_pkg::EXP_W,
  parameter int MAX_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic [7:0]        out_shift,
  output logic              out_zero,
  output logic              out_denorm
);
  import fp_pkg::*;

  localparam int LZ_W = $clog2(MAX_STEP + 1);

  norm_state_t       state_q, state_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [LZ_W-1:0]   lz;
  logic [EXP_W-1:0]  budget;
  logic [EXP_W-1:0]  lz_ext;
  logic [EXP_W-1:0]  k;
  logic [MANT_W-1:0] mant_sh;
  logic [EXP_W-1:0]  exp_sh;
  logic              step_done;
  logic              accept;
  logic              msb;

  lzd_window #(.W(MAX_STEP)) u_lzd (
    .win (mant_q[MANT_W-1 -: MAX_STEP]),
    .lz  (lz)
  );

  assign accept = in_valid && in_ready;

  // Zero or subnormal operands must not move: k is forced to 0.
  always_comb begin
    budget = (exp_q == '0) ? '0 : exp_q - EXP_W'(1);
    lz_ext = EXP_W'(lz);
    if (mant_q == '0) k = '0;
    else k = (lz_ext < budget) ? lz_ext : budget;
    mant_sh = mant_q << k;
    exp_sh  = exp_q - k;
    step_done = mant_sh[MANT_W-1] ||
                (exp_sh == EXP_W'(1)) ||
                (mant_q == '0) ||
                (exp_q == '0);
  end

  always_comb begin
    mant_d = mant_q;
    exp_d  = exp_q;
    cnt_d  = cnt_q;
    if (state_q == IDLE && accept) begin
      mant_d = in_mant;
      exp_d  = in_exp;
      cnt_d  = '0;
    end else if (state_q == SHIFT) begin
      mant_d = mant_sh;
      exp_d  = exp_sh;
      cnt_d  = cnt_q + 8'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mant_q  <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (step_done) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign msb = mant_q[MANT_W-1];

  always_comb begin
    in_ready   = (state_q == IDLE) && !rst;
    out_valid  = (state_q == DONE);
    out_mant   = '0;
    out_exp    = '0;
    out_shift  = '0;
    out_zero   = 1'b0;
    out_denorm = 1'b0;
    if (state_q == DONE) begin
      out_mant   = mant_q;
      out_shift  = cnt_q;
      out_zero   = (mant_q == '0);
      out_denorm = !out_zero && ((exp_q == '0) || !msb);
      out_exp    = ((exp_q == '0) || !msb) ? '0 : exp_q;
    end
  end
endmodule

// File: tb/tb_norm_shift_seq.sv
// Bench for norm_shift_seq: directed vectors,
// reference model and per-cycle output compare.
module tb_norm_shift_seq;
  localparam int MW = 24;
  localparam int EW = 8;
  localparam int MS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [MW-1:0] in_mant = '0;
  logic [EW-1:0] in_exp = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic [7:0]    out_shift;
  logic          out_zero;
  logic          out_denorm;

  norm_shift_seq #(.MANT_W(MW), .EXP_W(EW), .MAX_STEP(MS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_mant    (in_mant),
    .in_exp     (in_exp),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mant   (out_mant),
    .out_exp    (out_exp),
    .out_shift  (out_shift),
    .out_zero   (out_zero),
    .out_denorm (out_denorm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MW-1:0] mant;
    logic [EW-1:0] exp;
    logic [7:0]    shift;
    logic          zero;
    logic          den;
    int            lat;
  } res_t;

  res_t q[$];
  int   due_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc = 0;
  bit   vexp;
  bit   idle;
  res_t r;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Normalization from first principles: full-width leading zeros,
  // exponent floor of 1, and the per-cycle step bound on latency.
  function automatic res_t model(input logic [MW-1:0] m,
                                 input logic [EW-1:0] e);
    res_t o;
    int lz = 0;
    int ei = int'(e);
    int sh;
    o = '{default: 0};
    while (lz < MW && m[MW-1-lz] == 1'b0) lz++;
    if (m == '0) begin
      o.zero = 1'b1;
      o.lat = 1;
    end else if (ei == 0) begin
      o.mant = m;
      o.den = 1'b1;
      o.lat = 1;
    end else begin
      sh = (lz < ei - 1) ? lz : ei - 1;
      o.mant = m << sh;
      o.shift = 8'(sh);
      if (sh < lz) begin
        o.exp = '0;
        o.den = 1'b1;
      end else begin
        o.exp = EW'(ei - sh);
      end
      o.lat = (sh == 0) ? 1 : (sh + MS - 1) / MS;
    end
    return o;
  endfunction

  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      chk("in_ready_rst", 32'(in_ready), 32'(0));
      q.delete();
      due_q.delete();
    end else begin
      idle = (q.size() == 0);
      vexp = !idle && (ncyc >= due_q[0]);
      chk("in_ready", 32'(in_ready), 32'(idle));
      chk("out_valid", 32'(out_valid), 32'(vexp));
      if (vexp) begin
        chk("m_mant", 32'(out_mant), 32'(q[0].mant));
        chk("m_exp", 32'(out_exp), 32'(q[0].exp));
        chk("m_shift", 32'(out_shift), 32'(q[0].shift));
        chk("m_zero", 32'(out_zero), 32'(q[0].zero));
        chk("m_denorm", 32'(out_denorm), 32'(q[0].den));
        if (out_ready) begin
          void'(q.pop_front());
          void'(due_q.pop_front());
        end
      end else begin
        chk("idle_outs", {out_mant, out_exp},
            32'(0));
        chk("idle_flags", {22'(0), out_shift, out_zero, out_denorm},
            32'(0));
      end
      if (in_valid && idle) begin
        r = model(in_mant, in_exp);
        q.push_back(r);
        due_q.push_back(ncyc + 1 + r.lat);
      end
    end
  end

  task automatic send(input logic [MW-1:0] m, input logic [EW-1:0] e);
    int t = 0;
    in_mant = m;
    in_exp = e;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic expect_lit(input string tag, input logic [MW-1:0] em,
                            input logic [EW-1:0] ee, input logic [7:0] es,
                            input logic ez, input logic ed, input int el);
    int c = 0;
    while (c < 60) begin
      @(negedge clk);
      if (out_valid) break;
      c++;
    end
    chk({tag, "_lat"}, 32'(c), 32'(el));
    chk({tag, "_mant"}, 32'(out_mant), 32'(em));
    chk({tag, "_exp"}, 32'(out_exp), 32'(ee));
    chk({tag, "_shift"}, 32'(out_shift), 32'(es));
    chk({tag, "_zero"}, 32'(out_zero), 32'(ez));
    chk({tag, "_den"}, 32'(out_denorm), 32'(ed));
  endtask

  task automatic run(input string tag, input logic [MW-1:0] m,
                     input logic [EW-1:0] e, input logic [MW-1:0] em,
                     input logic [EW-1:0] ee, input logic [7:0] es,
                     input logic ez, input logic ed, input int el);
    send(m, e);
    expect_lit(tag, em, ee, es, ez, ed, el);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;

    run("c1", 24'h800000, 8'd100, 24'h800000, 8'd100, 8'd0, 0, 0, 1);
    run("c2", 24'h000001, 8'd100, 24'h800000, 8'd77, 8'd23, 0, 0, 6);
    run("c3", 24'h000100, 8'd5, 24'h001000, 8'd0, 8'd4, 0, 1, 1);
    run("c4", 24'h000000, 8'd50, 24'h000000, 8'd0, 8'd0, 1, 0, 1);
    run("sub", 24'h400000, 8'd0, 24'h400000, 8'd0, 8'd0, 0, 1, 1);
    run("e1", 24'h400000, 8'd1, 24'h400000, 8'd0, 8'd0, 0, 1, 1);
    run("w4", 24'h0F0000, 8'd10, 24'hF00000, 8'd6, 8'd4, 0, 0, 1);
    run("ex1", 24'h000100, 8'd16, 24'h800000, 8'd1, 8'd15, 0, 0, 4);

    // Backpressure: result must hold while downstream stalls.
    out_ready = 1'b0;
    send(24'h000001, 8'd100);
    expect_lit("c5", 24'h800000, 8'd77, 8'd23, 0, 0, 6);
    repeat (5) @(negedge clk);
    chk("c5_hold_valid", 32'(out_valid), 32'(1));
    chk("c5_hold_mant", 32'(out_mant), 32'(24'h800000));
    chk("c5_hold_ready", 32'(in_ready), 32'(0));
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("c5_release", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;

    send(24'h000010, 8'd30);
    send(24'h0000F0, 8'd3);
    send(24'h123456, 8'd200);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;

    // Abort an in-flight operand with reset.
    send(24'h000001, 8'd100);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("c6_valid", 32'(out_valid), 32'(0));
    chk("c6_mant", 32'(out_mant), 32'(0));
    chk("c6_shift", 32'(out_shift), 32'(0));
    chk("c6_ready", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    run("c6b", 24'h000100, 8'd5, 24'h001000, 8'd0, 8'd4, 0, 1, 1);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
